myproject_mul_su_pipe: RTL and testbench

Parametrised, pipelined signed-by-unsigned multiplier for the layernorm and dense datapaths.
- din0 is signed; din1 is unsigned (zero-extended by one bit before multiplying).
- The full product is right-shifted by a configurable amount, then wrapped or saturated to the output width.
- Sits between HLS-generated producer and consumer stages and carries valid/ready flow control with bubble collapse.
- Provides a sticky overflow flag for tuning runs.

---
 rtl/myproject_mul_su_pipe_if.sv | 25 ++
 rtl/myproject_mul_su_pipe.sv | 127 ++++++++++++
 tb/tb_myproject_mul_su_pipe.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/myproject_mul_su_pipe_if.sv
// Stream bundle for the signed-by-unsigned multiplier: operand input side and
// result output side, each with valid/ready flow control.
interface myproject_mul_su_pipe_if #(
  parameter int DIN0_W = 14,
  parameter int DIN1_W = 8,
  parameter int DOUT_W = 22
);
  logic              in_valid;
  logic              in_ready;
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dout;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/myproject_mul_su_pipe.sv
// Pipelined signed(din0) x unsigned(din1) multiplier with shift, wrap/saturate,
// bubble-collapsing valid/ready stages and a sticky overflow flag.
// Optional: define MYPROJECT_MUL_ROUND_EN for round-half-up before the shift.
module myproject_mul_su_pipe #(
  parameter int DIN0_W    = 14,
  parameter int DIN1_W    = 8,
  parameter int DOUT_W    = 22,
  parameter int SHIFT     = 0,
  parameter int SAT       = 0,
  parameter int NUM_STAGE = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  myproject_mul_su_pipe_if.slave  bus,
  output logic                    ovf_sticky,
  input  logic                    ovf_clr
);
  localparam int PW = DIN0_W + DIN1_W;
  localparam int SW = PW + 1;
  localparam int N  = NUM_STAGE;

  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  last_prod;
  logic [N-1:0]          valid_reg;
  logic [N-1:0]          stage_ready;
  logic [N-1:0]          up_valid;
  logic signed [SW-1:0]  ext;
  logic signed [SW-1:0]  rnd;
  logic signed [SW-1:0]  shifted;
  logic [DOUT_W-1:0]     res;
  logic                  res_ovf;
  logic [DOUT_W-1:0]     dout_reg;
  logic                  ovf_reg;

  // Both operands widened to PW; din1 gets zero fill so it stays non-negative.
  assign prod = $signed({{DIN1_W{bus.din0[DIN0_W-1]}}, bus.din0})
              * $signed({{DIN0_W{1'b0}}, bus.din1});

  always_comb begin
    up_valid[0] = bus.in_valid;
    for (int k = 1; k < N; k++) up_valid[k] = valid_reg[k-1];
  end

  // A stage can take new data when empty or when its content moves on.
  always_comb begin
    stage_ready[N-1] = !valid_reg[N-1] || bus.out_ready;
    for (int k = N - 2; k >= 0; k--) stage_ready[k] = !valid_reg[k] || stage_ready[k+1];
  end

  assign bus.in_ready  = stage_ready[0];
  assign bus.out_valid = valid_reg[N-1];
  assign bus.dout      = dout_reg;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_reg <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (stage_ready[k]) valid_reg[k] <= up_valid[k];
    end
  end

  generate
    if (N == 1) begin : g_comb
      assign last_prod = prod;
    end else begin : g_pipe
      logic signed [PW-1:0] prod_reg [N-1];
      for (genvar gi = 0; gi < N - 1; gi++) begin : g_stg
        if (gi == 0) begin : g_first
          always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) prod_reg[gi] <= '0;
            else if (stage_ready[gi] && up_valid[gi]) prod_reg[gi] <= prod;
          end
        end else begin : g_mid
          always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) prod_reg[gi] <= '0;
            else if (stage_ready[gi] && up_valid[gi]) prod_reg[gi] <= prod_reg[gi-1];
          end
        end
      end
      assign last_prod = prod_reg[N-2];
    end
  endgenerate

  // One guard bit keeps the rounding add from wrapping.
  assign ext = {last_prod[PW-1], last_prod};
`ifdef MYPROJECT_MUL_ROUND_EN
  localparam logic signed [SW-1:0] RND_K =
      (SHIFT > 0) ? (SW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  assign rnd = ext + RND_K;
`else
  assign rnd = ext;
`endif
  assign shifted = rnd >>> SHIFT;

  generate
    if (DOUT_W >= SW) begin : g_wide
      assign res     = DOUT_W'(shifted);
      assign res_ovf = 1'b0;
    end else begin : g_narrow
      localparam logic [DOUT_W-1:0] MAXV = {1'b0, {(DOUT_W-1){1'b1}}};
      localparam logic [DOUT_W-1:0] MINV = {1'b1, {(DOUT_W-1){1'b0}}};
      logic [SW-DOUT_W:0] hi;
      // In range only when all bits from the output sign bit upward agree.
      assign hi      = shifted[SW-1:DOUT_W-1];
      assign res_ovf = !((&hi) || !(|hi));
      assign res     = (SAT != 0 && res_ovf) ? (shifted[SW-1] ? MINV : MAXV)
                                             : shifted[DOUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (stage_ready[N-1] && up_valid[N-1]) begin
      dout_reg <= res;
      ovf_reg  <= res_ovf;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) ovf_sticky <= 1'b0;
    else if (ovf_clr) ovf_sticky <= 1'b0;
    else if (valid_reg[N-1] && bus.out_ready && ovf_reg) ovf_sticky <= 1'b1;
  end
endmodule

// File: tb/tb_myproject_mul_su_pipe.sv
// Three multiplier configurations driven in lockstep, checked against an
// arithmetic reference model and an in-order expectation queue.
module tb_myproject_mul_su_pipe;
  logic ap_clk = 1'b0;
  logic rst_n  = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic [13:0] din0_drv = '0;
  logic [7:0]  din1_drv = '0;
  logic ovf0, ovf1, ovf2;

  int tests = 0;
  int fails = 0;
  int nxfer = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_mul_su_pipe_if #(.DIN0_W(14), .DIN1_W(8), .DOUT_W(22)) bus0 ();
  myproject_mul_su_pipe_if #(.DIN0_W(14), .DIN1_W(8), .DOUT_W(16)) bus1 ();
  myproject_mul_su_pipe_if #(.DIN0_W(14), .DIN1_W(8), .DOUT_W(16)) bus2 ();

  assign bus0.in_valid = in_valid;  assign bus0.din0 = din0_drv;
  assign bus0.din1 = din1_drv;      assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid;  assign bus1.din0 = din0_drv;
  assign bus1.din1 = din1_drv;      assign bus1.out_ready = out_ready;
  assign bus2.in_valid = in_valid;  assign bus2.din0 = din0_drv;
  assign bus2.din1 = din1_drv;      assign bus2.out_ready = out_ready;

  myproject_mul_su_pipe #(.DIN0_W(14), .DIN1_W(8), .DOUT_W(22), .SHIFT(0), .SAT(0), .NUM_STAGE(2))
    u0 (.ap_clk(ap_clk), .ap_rst_n(rst_n), .bus(bus0), .ovf_sticky(ovf0), .ovf_clr(ovf_clr));
  myproject_mul_su_pipe #(.DIN0_W(14), .DIN1_W(8), .DOUT_W(16), .SHIFT(0), .SAT(1), .NUM_STAGE(2))
    u1 (.ap_clk(ap_clk), .ap_rst_n(rst_n), .bus(bus1), .ovf_sticky(ovf1), .ovf_clr(ovf_clr));
  myproject_mul_su_pipe #(.DIN0_W(14), .DIN1_W(8), .DOUT_W(16), .SHIFT(4), .SAT(0), .NUM_STAGE(2))
    u2 (.ap_clk(ap_clk), .ap_rst_n(rst_n), .bus(bus2), .ovf_sticky(ovf2), .ovf_clr(ovf_clr));

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, optional round, floor shift, then range handling.
  function automatic longint model(input int a, input int b, input int dw, input int sh,
                                   input int sat, output bit ovf);
    longint p, s, mn, mx, w;
    p = longint'(a) * longint'(b);
`ifdef MYPROJECT_MUL_ROUND_EN
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
    s  = p >>> sh;
    mn = -(longint'(1) << (dw - 1));
    mx = -mn - 1;
    ovf = (s < mn) || (s > mx);
    if (!ovf) return s;
    if (sat != 0) return (s < mn) ? mn : mx;
    w = s & ((longint'(1) << dw) - 1);
    if (w > mx) w = w - (longint'(1) << dw);
    return w;
  endfunction

  typedef struct {
    longint v0, v1, v2;
    bit     o0, o1, o2;
  } exp_t;
  exp_t exp_q[$];
  bit s0 = 0, s1 = 0, s2 = 0;
  bit hold_prev = 0;

  always @(negedge ap_clk) begin
    exp_t e;
    bit   xfer;
    int   a, b;
    if (!rst_n) begin
      exp_q.delete();
      s0 = 0; s1 = 0; s2 = 0;
      hold_prev = 0;
    end else begin
      if (bus0.out_valid || bus1.out_valid || bus2.out_valid) begin
        if (exp_q.size() == 0) check("stale_out", 1, 0);
        else begin
          if (bus0.out_valid) check("dout_u0", longint'($signed(bus0.dout)), exp_q[0].v0);
          if (bus1.out_valid) check("dout_u1", longint'($signed(bus1.dout)), exp_q[0].v1);
          if (bus2.out_valid) check("dout_u2", longint'($signed(bus2.dout)), exp_q[0].v2);
        end
      end
      if (hold_prev) check("hold_valid", longint'(bus0.out_valid), 1);
      hold_prev = bus0.out_valid && !out_ready;
      check("sticky_u0", longint'(ovf0), longint'(s0));
      check("sticky_u1", longint'(ovf1), longint'(s1));
      check("sticky_u2", longint'(ovf2), longint'(s2));
      xfer = bus0.out_valid && out_ready && exp_q.size() != 0;
      if (ovf_clr) begin
        s0 = 0; s1 = 0; s2 = 0;
      end else if (xfer) begin
        s0 = s0 | exp_q[0].o0; s1 = s1 | exp_q[0].o1; s2 = s2 | exp_q[0].o2;
      end
      if (xfer) begin
        $display("[TB] xfer %0d: dout u0=%0d u1=%0d u2=%0d", nxfer,
                 $signed(bus0.dout), $signed(bus1.dout), $signed(bus2.dout));
        nxfer++;
        void'(exp_q.pop_front());
      end
      if (in_valid && bus0.in_ready) begin
        a = int'($signed(din0_drv));
        b = int'(din1_drv);
        e.v0 = model(a, b, 22, 0, 0, e.o0);
        e.v1 = model(a, b, 16, 0, 1, e.o1);
        e.v2 = model(a, b, 16, 4, 0, e.o2);
        exp_q.push_back(e);
      end
    end
  end

  int a0[$];
  int a1[$];

  // mode 0: out_ready=1; 1: random; 2: out_ready=0; 3: stall on cycles 3..6
  task automatic run_items(input int mode);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    while (idx < a0.size()) begin
      in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      din0_drv = 14'(a0[idx]);
      din1_drv = 8'(a1[idx]);
      case (mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        3:       out_ready = !(cyc >= 3 && cyc <= 6);
        default: out_ready = 1'b1;
      endcase
      ovf_clr = (mode == 1) ? ($urandom_range(0, 15) == 0) : 1'b0;
      @(negedge ap_clk);
      if (mode == 3 && cyc == 5) check("full_in_ready", longint'(bus0.in_ready), 0);
      acc = in_valid && bus0.in_ready;
      @(posedge ap_clk); #1;
      if (acc) idx++;
      cyc++;
      if (cyc > 5000) begin
        check("feed_timeout", idx, a0.size());
        break;
      end
    end
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(posedge ap_clk); #1;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_out_valid", longint'(bus0.out_valid), 0);
    check("rst_dout", longint'(bus0.dout), 0);
    check("rst_sticky", longint'(ovf0), 0);
    check("rst_in_ready", longint'(bus0.in_ready), 1);
    @(posedge ap_clk); #1;
    rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Latency from acceptance with no backpressure
    out_ready = 1'b1;
    in_valid = 1'b1; din0_drv = 14'(-8192); din1_drv = 8'd255;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!bus0.out_valid && n < 10) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check("latency", n, 2);
    check("t1_dout", longint'($signed(bus0.dout)), -2088960);
    drain();

    // Directed corner operands
    a0 = '{-8192, 8191, -25, 24, -8, -1, 0, -8192, 8191, -24};
    a1 = '{255, 255, 1, 1, 1, 255, 0, 0, 1, 1};
    run_items(0);
    drain();

    // 8 back-to-back with a 4-cycle output stall
    a0.delete(); a1.delete();
    for (int i = 0; i < 8; i++) begin
      a0.push_back(i * 1000 - 4000);
      a1.push_back(i * 30 + 7);
    end
    run_items(3);
    drain();

    // Async reset with two results in flight
    a0 = '{1234, -4321};
    a1 = '{17, 200};
    run_items(2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", longint'(bus0.out_valid), 0);
    check("rst_async_dout", longint'(bus0.dout), 0);
    @(posedge ap_clk); #1;
    rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_in_ready", longint'(bus0.in_ready), 1);
    check("post_rst_valid", longint'(bus0.out_valid), 0);
    out_ready = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;

    // ovf_clr coinciding with an overflowing transfer
    a0 = '{8191};
    a1 = '{255};
    run_items(2);
    @(posedge ap_clk); #1;
    check("ovf_pending_valid", longint'(bus1.out_valid), 1);
    out_ready = 1'b1;
    ovf_clr = 1'b1;
    @(posedge ap_clk); #1;
    ovf_clr = 1'b0;
    check("clr_priority", longint'(ovf1), 0);
    run_items(0);
    drain();
    check("ovf_set_again", longint'(ovf1), 1);

    // Randomized traffic with backpressure and sporadic clears
    a0.delete(); a1.delete();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       a0.push_back(-8192);
        1:       a0.push_back(8191);
        default: a0.push_back(int'($urandom_range(0, 16383)) - 8192);
      endcase
      a1.push_back(($urandom_range(0, 4) == 0) ? 255 : int'($urandom_range(0, 255)));
    end
    run_items(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end
endmodule
